// File: rtl/switch_conditioner_if.sv
// Switch conditioner bus: raw switch levels in, clean levels and strobes out.
// Optional status signals exist only when SW_CONDITIONER_STATUS_EN is defined.
interface switch_conditioner_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] SW;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             ready;
`ifdef SW_CONDITIONER_STATUS_EN
  logic [WIDTH-1:0] unstable;
  logic [7:0]       glitch_cnt;

  // Switch side drives the raw levels and consumes the conditioned outputs.
  modport master (
    output SW,
    input  sw_clean, rise, fall, ready, unstable, glitch_cnt
  );

  // Conditioner side.
  modport slave (
    input  SW,
    output sw_clean, rise, fall, ready, unstable, glitch_cnt
  );
`else
  // Switch side drives the raw levels and consumes the conditioned outputs.
  modport master (
    output SW,
    input  sw_clean, rise, fall, ready
  );

  // Conditioner side.
  modport slave (
    input  SW,
    output sw_clean, rise, fall, ready
  );
`endif
endinterface

// File: rtl/switch_conditioner.sv
// Slide-switch front end: per-bit 2-FF synchronizer, debounce and edge strobes.
// After reset an init phase captures the current switch levels without strobes,
// then ready goes high and each bit debounces independently.
// Optional status outputs (unstable, glitch_cnt) are built when the macro
// SW_CONDITIONER_STATUS_EN is defined.
module switch_conditioner #(
  parameter int WIDTH         = 16,
  parameter bit SIM           = 1'b0,
  parameter int DB_CYCLES     = 1_000_000,
  parameter int SIM_DB_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  switch_conditioner_if.slave bus
);

  localparam int N     = SIM ? SIM_DB_CYCLES : DB_CYCLES;
  localparam int CNT_W = $clog2(N + 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(N + 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W-1:0] init_q, init_d;
  logic             ready_q, ready_d;

  // Next-state: init capture until ready, then per-bit debounce with strobes.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    init_d  = init_q;
    ready_d = ready_q;
    if (!ready_q) begin
      clean_d = sync2_q;
      for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
      if (init_q == INIT_LAST) ready_d = 1'b1;
      else                     init_d  = init_q + 1'b1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == clean_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // State registers, including the synchronizer pair with nothing between them.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      init_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      sync1_q <= bus.SW;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      ready_q <= ready_d;
    end
  end

  assign bus.sw_clean = clean_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.ready    = ready_q;

`ifdef SW_CONDITIONER_STATUS_EN
  logic [WIDTH-1:0] unstable;
  logic [WIDTH-1:0] abort;
  logic [7:0]       glitch_q, glitch_d;
  int               glitchSum;

  // A bit is unstable while it has a partial count; an abort is a partial
  // count that ends because the level returned to the clean value.
  always_comb begin
    unstable  = '0;
    abort     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unstable[i] = (cnt_q[i] != '0);
      abort[i]    = ready_q && (cnt_q[i] != '0) && (sync2_q[i] == clean_q[i]);
    end
    glitchSum = int'(glitch_q) + $countones(abort);
    glitch_d  = (glitchSum > 255) ? 8'hFF : glitchSum[7:0];
  end

  // Saturating count of aborted transitions.
  always_ff @(posedge clk) begin
    if (reset) glitch_q <= '0;
    else       glitch_q <= glitch_d;
  end

  assign bus.unstable   = unstable;
  assign bus.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner (SIM=1, N=4).
// Reference model decides debounce by a sliding window of the last N
// synchronized samples seen in the run phase.
module tb_switch_conditioner;

  localparam int WIDTH = 16;
  localparam int N     = 4;

  logic clk = 1'b0;
  logic reset;

  switch_conditioner_if #(.WIDTH(WIDTH)) bus ();

  switch_conditioner #(
    .WIDTH(WIDTH), .SIM(1'b1), .DB_CYCLES(1_000_000), .SIM_DB_CYCLES(N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Reference model state.
  logic [WIDTH-1:0] swD1, swD2;
  logic [WIDTH-1:0] expClean, expRise, expFall, pend;
  logic             expReady;
  logic [WIDTH-1:0] window [$];
  int               initEdges;
  int               expGlitch;

  // Observation bookkeeping for the directed scenarios.
  int riseSeen [WIDTH];
  int fallSeen [WIDTH];
  int cyclesSinceRelease;
  int readyCycle;
  int coincidences;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one rising edge.
  task automatic modelEdge(input logic [WIDTH-1:0] swIn, input logic rstIn);
    logic [WIDTH-1:0] sample;
    bit               allSame;
    expRise = '0;
    expFall = '0;
    if (rstIn) begin
      swD1 = '0; swD2 = '0; expClean = '0; expReady = 1'b0; pend = '0;
      initEdges = 0; expGlitch = 0;
      window.delete();
    end else begin
      sample = swD2;
      if (!expReady) begin
        expClean = sample;
        pend     = '0;
        initEdges++;
        if (initEdges == N + 2) expReady = 1'b1;
      end else begin
        window.push_back(sample);
        if (window.size() > N) void'(window.pop_front());
        for (int i = 0; i < WIDTH; i++) begin
          allSame = (window.size() == N);
          foreach (window[j]) if (window[j][i] != sample[i]) allSame = 0;
          if (sample[i] == expClean[i]) begin
            if (pend[i] && expGlitch < 255) expGlitch++;
            pend[i] = 1'b0;
          end else if (allSame) begin
            expClean[i] = sample[i];
            expRise[i]  = sample[i];
            expFall[i]  = ~sample[i];
            pend[i]     = 1'b0;
          end else begin
            pend[i] = 1'b1;
          end
        end
      end
      swD2 = swD1;
      swD1 = swIn;
    end
  endtask

  // Drive one cycle of inputs, step the model and compare all outputs.
  task automatic applyStimulus(input logic [WIDTH-1:0] swIn, input logic rstIn);
    bus.SW = swIn;
    reset  = rstIn;
    @(posedge clk);
    modelEdge(swIn, rstIn);
    #1;
    checkOutput("sw_clean", 32'(bus.sw_clean), 32'(expClean));
    checkOutput("rise", 32'(bus.rise), 32'(expRise));
    checkOutput("fall", 32'(bus.fall), 32'(expFall));
    checkOutput("ready", 32'(bus.ready), 32'(expReady));
    checkOutput("rise_and_fall", 32'(bus.rise & bus.fall), 32'd0);
`ifdef SW_CONDITIONER_STATUS_EN
    checkOutput("unstable", 32'(bus.unstable), 32'(pend));
    checkOutput("glitch_cnt", 32'(bus.glitch_cnt), 32'(expGlitch));
`endif
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.rise[i]) riseSeen[i]++;
      if (bus.fall[i]) fallSeen[i]++;
    end
    if (bus.rise[13] && bus.rise[14] && bus.fall[6]) coincidences++;
    if (rstIn) begin
      cyclesSinceRelease = 0;
      readyCycle         = -1;
    end else begin
      cyclesSinceRelease++;
      if (bus.ready && readyCycle < 0) readyCycle = cyclesSinceRelease;
    end
  endtask

  task automatic holdFor(input logic [WIDTH-1:0] swIn, input int cycles);
    repeat (cycles) applyStimulus(swIn, 1'b0);
  endtask

  function automatic int strobeTotal();
    int s = 0;
    for (int i = 0; i < WIDTH; i++) s += riseSeen[i] + fallSeen[i];
    return s;
  endfunction

  initial begin
    logic [WIDTH-1:0] sw;
    int baseTotal, baseCoinc;
    int baseRise [WIDTH];
    int baseFall [WIDTH];
    int loadRise [WIDTH];
    int loadFall [WIDTH];
    int loadSeq [5];
    logic [3:0] x, y;

    for (int i = 0; i < WIDTH; i++) begin
      riseSeen[i] = 0; fallSeen[i] = 0; loadRise[i] = 0; loadFall[i] = 0;
    end
    cyclesSinceRelease = 0; readyCycle = -1; coincidences = 0;
    swD1 = '0; swD2 = '0; expClean = '0; expRise = '0; expFall = '0;
    pend = '0; expReady = 1'b0; initEdges = 0; expGlitch = 0;

    // 1: reset, release with SW=00E0, initial capture without strobes.
    sw = 16'h00E0;
    repeat (3) applyStimulus(sw, 1'b1);
    holdFor(sw, 10);
    checkOutput("ready_latency", 32'(readyCycle), 32'd6);
    checkOutput("init_capture", 32'(bus.sw_clean), 32'h00E0);
    checkOutput("init_no_strobe", 32'(strobeTotal()), 32'd0);

    // 2: SW[7] 1->0 gives one fall[7] pulse and nothing else.
    baseTotal = strobeTotal();
    baseFall[7] = fallSeen[7];
    sw = 16'h0060;
    holdFor(sw, 10);
    checkOutput("fall7_count", 32'(fallSeen[7] - baseFall[7]), 32'd1);
    checkOutput("fall7_only", 32'(strobeTotal() - baseTotal), 32'd1);
    checkOutput("clean7_low", 32'(bus.sw_clean[7]), 32'd0);

    // 3: SW[0] high for 3 cycles is a glitch.
    baseRise[0] = riseSeen[0];
    holdFor(16'h0061, 3);
    holdFor(sw, 8);
    checkOutput("glitch_no_rise", 32'(riseSeen[0] - baseRise[0]), 32'd0);
    checkOutput("glitch_clean0", 32'(bus.sw_clean[0]), 32'd0);
`ifdef SW_CONDITIONER_STATUS_EN
    checkOutput("glitch_cnt_one", 32'(bus.glitch_cnt), 32'd1);
`endif

    // 4: SW[14:13] 00->11 and SW[6] 1->0 together.
    baseCoinc = coincidences;
    sw = 16'h6020;
    holdFor(sw, 10);
    checkOutput("same_cycle_strobes", 32'(coincidences - baseCoinc), 32'd1);

    // 5: SW[5] change interrupted by reset.
    baseTotal = strobeTotal();
    sw = 16'h6000;
    holdFor(sw, 2);
    repeat (3) applyStimulus(sw, 1'b1);
    holdFor(sw, 12);
    checkOutput("reset_mid_no_strobe", 32'(strobeTotal() - baseTotal), 32'd0);
    checkOutput("reset_ready_latency", 32'(readyCycle), 32'd6);
    checkOutput("reset_clean5", 32'(bus.sw_clean[5]), 32'd0);

    // 6: datapath replay with load pulses on SW[7]/[6]/[5]/[0].
    x = 4'hA; y = 4'h7;
    sw = 16'h6000 | (16'(x) << 1) | (16'(y) << 9);
    holdFor(sw, 10);
    for (int i = 0; i < WIDTH; i++) begin
      baseRise[i] = riseSeen[i]; baseFall[i] = fallSeen[i];
    end
    loadSeq = '{7, 6, 5, 0, 7};
    foreach (loadSeq[k]) begin
      holdFor(sw | (16'd1 << loadSeq[k]), 8);
      holdFor(sw, 8);
      loadRise[loadSeq[k]]++;
      loadFall[loadSeq[k]]++;
    end
    foreach (loadSeq[k]) begin
      if (k < 4) begin
        checkOutput($sformatf("load_rise_%0d", loadSeq[k]),
                    32'(riseSeen[loadSeq[k]] - baseRise[loadSeq[k]]), 32'(loadRise[loadSeq[k]]));
        checkOutput($sformatf("load_fall_%0d", loadSeq[k]),
                    32'(fallSeen[loadSeq[k]] - baseFall[loadSeq[k]]), 32'(loadFall[loadSeq[k]]));
      end
    end

    // 7: randomized toggles and glitches with occasional resets.
    repeat (80) begin
      sw ^= 16'd1 << $urandom_range(0, WIDTH - 1);
      if ($urandom_range(0, 3) == 0) sw ^= 16'd1 << $urandom_range(0, WIDTH - 1);
      holdFor(sw, $urandom_range(1, 8));
      if ($urandom_range(0, 19) == 0) repeat (2) applyStimulus(sw, 1'b1);
    end
    holdFor(sw, 12);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
